// File: rtl/gpio_ctrl_pkg.sv
// Shared definitions for the GPIO APB controller.
// Holds the sequencer and transfer state encodings, the slave register map
// and the bit layout of one CONFIG_x register.
package gpio_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_RUN,
        ST_IRQ_RD,
        ST_IRQ_CLR,
        ST_OUT_WR
    } ctrl_state_t;

    typedef enum logic [1:0] {
        X_IDLE,
        X_SETUP,
        X_ACCESS
    } xfer_state_t;

    // Slave register map
    localparam logic [7:0] CONFIG_BASE = 8'h00;
    localparam logic [7:0] INTR_ADDR   = 8'h80;
    localparam logic [7:0] OUT_ADDR    = 8'hA0;

    // Bit positions inside one CONFIG_x image
    localparam int CFG_DIR_BIT    = 0;  // 1 = output
    localparam int CFG_INT_EN_BIT = 1;  // interrupt enable
    localparam int CFG_INT_TYPE   = 2;  // 1 = edge, 0 = level
    localparam int CFG_INT_POL    = 3;  // 1 = rising/high

    // Byte address of CONFIG_idx
    function automatic logic [7:0] cfg_addr(input logic [4:0] idx);
        return CONFIG_BASE + {1'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/gpio_apb_xfer.sv
// APB master handshake: one SETUP cycle, then ACCESS until PREADY.
// Ports:
//   PCLK, PRESET        clock, synchronous active-high reset
//   start, wr, addr,    request a transfer; accepted when idle or on the
//   wdata               completing cycle, so back-to-back transfers chain
//   busy                a transfer is in SETUP or ACCESS
//   done                completing cycle (ACCESS and PREADY)
//   PSEL..PWDATA        APB master outputs, PREADY input
module gpio_apb_xfer
    import gpio_ctrl_pkg::*;
(
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        start,
    input  logic        wr,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    input  logic        PREADY,
    output logic        busy,
    output logic        done,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [7:0]  PADDR,
    output logic [31:0] PWDATA
);

    xfer_state_t state_q, state_d;
    logic        accept;

    assign done    = (state_q == X_ACCESS) && PREADY;
    // Taking a new request on the completing cycle avoids an idle cycle.
    assign accept  = start && ((state_q == X_IDLE) || done);
    assign busy    = (state_q != X_IDLE);
    assign PSEL    = busy;
    assign PENABLE = (state_q == X_ACCESS);

    always_comb begin
        state_d = state_q;
        case (state_q)
            X_IDLE:   if (start) state_d = X_SETUP;
            X_SETUP:  state_d = X_ACCESS;
            X_ACCESS: if (PREADY) state_d = start ? X_SETUP : X_IDLE;
            default:  state_d = X_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= X_IDLE;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                PWRITE <= wr;
                PADDR  <= addr;
                PWDATA <= wdata;
            end
        end
    end

endmodule

// File: rtl/gpio_apb_ctrl.sv
// Sequencer that configures a GPIO slave over APB, then services its
// interrupt and GPIO_OUT write requests.
// Ports:
//   PCLK, PRESET          clock, synchronous active-high reset
//   cfg_start, cfg_vec    launch CONFIG_0..CONFIG_(IO_NUM-1) writes
//   cfg_done              high while in RUN
//   out_req, out_data,    GPIO_OUT write request, ack on completion
//   out_ack
//   INT_OR                level interrupt from the slave
//   irq_valid, irq_vec    serviced interrupt vector, pulsed with the clear
//   err                   sticky PSLVERR flag
//   PSEL..PSLVERR         APB master interface
module gpio_apb_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int IO_NUM = 8,
    parameter int CFG_W  = 8
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    cfg_start,
    input  logic [CFG_W*IO_NUM-1:0] cfg_vec,
    output logic                    cfg_done,
    input  logic                    out_req,
    input  logic [IO_NUM-1:0]       out_data,
    output logic                    out_ack,
    input  logic                    INT_OR,
    output logic                    irq_valid,
    output logic [IO_NUM-1:0]       irq_vec,
    output logic                    err,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [7:0]              PADDR,
    output logic [31:0]             PWDATA,
    input  logic [31:0]             PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int IDX_W = (IO_NUM > 1) ? $clog2(IO_NUM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IO_NUM - 1);

    ctrl_state_t       state_q, state_d;
    logic [IDX_W-1:0]  cfg_idx_q, launch_idx;
    logic              irq_arm_q, irq_launch;
    logic              x_start, x_wr, x_busy, x_done;
    logic [7:0]        x_addr;
    logic [31:0]       x_wdata;
    logic [IO_NUM-1:0] intr_rd;
    logic              prdata_unused;

    assign intr_rd       = PRDATA[IO_NUM-1:0];
    assign prdata_unused = ^PRDATA;
    // On a completing CFG cycle the next CONFIG index is launched at once.
    assign launch_idx    = x_done ? cfg_idx_q + 1'b1 : cfg_idx_q;
    // Re-arming needs a RUN cycle with INT_OR low, so a level interrupt that
    // the slave has not yet dropped is not serviced twice.
    assign irq_launch    = (state_q == ST_RUN) && INT_OR && irq_arm_q;

    assign cfg_done  = (state_q == ST_RUN);
    assign out_ack   = (state_q == ST_OUT_WR) && x_done;
    assign irq_valid = (state_q == ST_IRQ_CLR) && x_done;

    always_comb begin
        state_d = state_q;
        x_start = 1'b0;
        x_wr    = 1'b0;
        x_addr  = '0;
        x_wdata = '0;
        case (state_q)
            ST_IDLE: if (cfg_start) state_d = ST_CFG;
            ST_CFG: begin
                if (x_done && cfg_idx_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end else if (!x_busy || x_done) begin
                    x_start = 1'b1;
                    x_wr    = 1'b1;
                    x_addr  = cfg_addr(5'(launch_idx));
                    x_wdata = 32'(cfg_vec[CFG_W*int'(launch_idx) +: CFG_W]);
                end
            end
            ST_RUN: begin
                if (irq_launch) begin
                    x_start = 1'b1;
                    x_addr  = INTR_ADDR;
                    state_d = ST_IRQ_RD;
                end else if (out_req) begin
                    x_start = 1'b1;
                    x_wr    = 1'b1;
                    x_addr  = OUT_ADDR;
                    x_wdata = 32'(out_data);
                    state_d = ST_OUT_WR;
                end
            end
            ST_IRQ_RD: begin
                if (x_done) begin
                    if (intr_rd != '0) begin
                        x_start = 1'b1;
                        x_wr    = 1'b1;
                        x_addr  = INTR_ADDR;
                        x_wdata = 32'(intr_rd);
                        state_d = ST_IRQ_CLR;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_IRQ_CLR: if (x_done) state_d = ST_RUN;
            ST_OUT_WR:  if (x_done) state_d = ST_RUN;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            cfg_idx_q <= '0;
            irq_vec   <= '0;
            irq_arm_q <= 1'b1;
            err       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE)
                cfg_idx_q <= '0;
            else if (state_q == ST_CFG && x_done)
                cfg_idx_q <= cfg_idx_q + 1'b1;
            if (state_q == ST_IRQ_RD && x_done)
                irq_vec <= intr_rd;
            if (irq_launch)
                irq_arm_q <= 1'b0;
            else if (state_q == ST_RUN && !INT_OR)
                irq_arm_q <= 1'b1;
            if (x_done && PSLVERR)
                err <= 1'b1;
        end
    end

    gpio_apb_xfer u_xfer (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .start   (x_start),
        .wr      (x_wr),
        .addr    (x_addr),
        .wdata   (x_wdata),
        .PREADY  (PREADY),
        .busy    (x_busy),
        .done    (x_done),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA)
    );

endmodule

// File: tb/tb_gpio_apb_ctrl.sv
// Directed bench for gpio_apb_ctrl with a scoreboard: stimulus pushes the
// expected APB transfers and ack/irq events, a negedge monitor pops and
// compares whenever the DUT completes a transfer or pulses an event.
// A second IO_NUM=4 instance checks the small configuration case.
module tb_gpio_apb_ctrl;

    localparam int IO = 8;
    localparam int CW = 8;

    typedef enum {K_APB, K_ACK, K_IRQ} kind_t;
    typedef struct {
        kind_t       kind;
        logic [7:0]  addr;
        logic        wr;
        logic [31:0] data;
    } item_t;

    logic              PCLK = 1'b0;
    logic              PRESET = 1'b1;
    logic              cfg_start = 1'b0;
    logic [CW*IO-1:0]  cfg_vec = '0;
    logic              cfg_done;
    logic              out_req = 1'b0;
    logic [IO-1:0]     out_data = '0;
    logic              out_ack;
    logic              INT_OR = 1'b0;
    logic              irq_valid;
    logic [IO-1:0]     irq_vec;
    logic              err;
    logic              PSEL, PENABLE, PWRITE;
    logic [7:0]        PADDR;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    // small instance
    logic              cfg_start4 = 1'b0;
    logic [31:0]       cfg_vec4 = 32'h0F0E_0D0C;
    logic              cfg_done4, out_ack4, irq_valid4, err4;
    logic [3:0]        irq_vec4;
    logic              psel4, pen4, pwr4;
    logic [7:0]        paddr4;
    logic [31:0]       pwdata4;

    // slave model controls (written by stimulus only)
    int                ws_target = 0;
    logic              slverr_en = 1'b0;
    logic [7:0]        slverr_addr = 8'h08;
    logic [31:0]       intr_val = '0;

    item_t sbq[$];
    item_t q4[$];
    int    vectors = 0;
    int    miscompares = 0;

    always #5 PCLK = ~PCLK;

    gpio_apb_ctrl #(.IO_NUM(IO), .CFG_W(CW)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .cfg_start(cfg_start), .cfg_vec(cfg_vec),
        .cfg_done(cfg_done), .out_req(out_req), .out_data(out_data), .out_ack(out_ack),
        .INT_OR(INT_OR), .irq_valid(irq_valid), .irq_vec(irq_vec), .err(err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    gpio_apb_ctrl #(.IO_NUM(4), .CFG_W(8)) dut4 (
        .PCLK(PCLK), .PRESET(PRESET), .cfg_start(cfg_start4), .cfg_vec(cfg_vec4),
        .cfg_done(cfg_done4), .out_req(1'b0), .out_data(4'h0), .out_ack(out_ack4),
        .INT_OR(1'b0), .irq_valid(irq_valid4), .irq_vec(irq_vec4), .err(err4),
        .PSEL(psel4), .PENABLE(pen4), .PWRITE(pwr4), .PADDR(paddr4),
        .PWDATA(pwdata4), .PRDATA(32'h0), .PREADY(1'b1), .PSLVERR(1'b0)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h need %0h", nm, got, exp);
        end
    endtask

    task automatic push(input kind_t k, input logic [7:0] a, input logic w, input logic [31:0] d);
        item_t it;
        it.kind = k; it.addr = a; it.wr = w; it.data = d;
        sbq.push_back(it);
    endtask

    task automatic check_item(input kind_t k);
        item_t e;
        logic  ok;
        vectors++;
        if (sbq.size() == 0) begin
            miscompares++;
            $display("FAIL sb_unexpected: got %s addr %h wr %b wdata %h irq_vec %h, nothing expected",
                     k.name(), PADDR, PWRITE, PWDATA, irq_vec);
            return;
        end
        e = sbq.pop_front();
        case (k)
            K_APB:   ok = (e.kind == K_APB) && (e.addr == PADDR) && (e.wr == PWRITE)
                          && (!e.wr || e.data == PWDATA);
            K_ACK:   ok = (e.kind == K_ACK);
            default: ok = (e.kind == K_IRQ) && (e.data[IO-1:0] == irq_vec);
        endcase
        if (!ok) begin
            miscompares++;
            $display("FAIL sb_%s: got %s addr %h wr %b wdata %h irq_vec %h, need %s addr %h wr %b data %h",
                     k.name(), k.name(), PADDR, PWRITE, PWDATA, irq_vec,
                     e.kind.name(), e.addr, e.wr, e.data);
        end
    endtask

    // Slave model: wait states, error response and INTR read data.
    initial begin
        int acc_cnt;
        acc_cnt = 0;
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        PRDATA  = '0;
        forever begin
            @(posedge PCLK);
            #1;
            if (PSEL && PENABLE) begin
                if (acc_cnt < ws_target) begin
                    PREADY = 1'b0;
                    acc_cnt++;
                end else begin
                    PREADY  = 1'b1;
                    acc_cnt = 0;
                end
            end else begin
                PREADY  = 1'b1;
                acc_cnt = 0;
            end
            PSLVERR = slverr_en && PSEL && PENABLE && (PADDR == slverr_addr);
            PRDATA  = (PADDR == 8'h80 && !PWRITE) ? intr_val : 32'h5A5A_0000;
        end
    end

    // Monitor for the main instance: phase stability plus scoreboard.
    initial begin
        logic        setup_seen;
        logic [7:0]  s_addr;
        logic        s_wr;
        logic [31:0] s_data;
        setup_seen = 1'b0;
        s_addr = '0; s_wr = 1'b0; s_data = '0;
        forever begin
            @(negedge PCLK);
            if (PRESET) begin
                setup_seen = 1'b0;
            end else begin
                if (PSEL && !PENABLE) begin
                    setup_seen = 1'b1;
                    s_addr = PADDR; s_wr = PWRITE; s_data = PWDATA;
                end else if (PSEL && PENABLE) begin
                    vectors++;
                    if (!setup_seen || PADDR != s_addr || PWRITE != s_wr || PWDATA != s_data) begin
                        miscompares++;
                        $display("FAIL apb_hold: got %h/%b/%h need %h/%b/%h after setup=%0b",
                                 PADDR, PWRITE, PWDATA, s_addr, s_wr, s_data, setup_seen);
                    end
                    if (PREADY) begin
                        setup_seen = 1'b0;
                        check_item(K_APB);
                    end
                end else begin
                    setup_seen = 1'b0;
                end
                if (out_ack)   check_item(K_ACK);
                if (irq_valid) check_item(K_IRQ);
            end
        end
    end

    // Monitor for the IO_NUM=4 instance (PREADY tied high).
    initial begin
        item_t e;
        forever begin
            @(negedge PCLK);
            if (!PRESET && psel4 && pen4) begin
                vectors++;
                if (q4.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb4_unexpected: got addr %h data %h", paddr4, pwdata4);
                end else begin
                    e = q4.pop_front();
                    if (paddr4 != e.addr || pwdata4 != e.data || !pwr4) begin
                        miscompares++;
                        $display("FAIL sb4_cfg: got addr %h wr %b data %h need addr %h wr 1 data %h",
                                 paddr4, pwr4, pwdata4, e.addr, e.data);
                    end
                end
            end
        end
    end

    // Pushes the expected CONFIG writes, pulses cfg_start and checks latency.
    task automatic run_cfg(input logic [63:0] v, input string nm);
        int n;
        for (int i = 0; i < IO; i++)
            push(K_APB, 8'(4 * i), 1'b1, 32'(v[8*i +: 8]));
        @(posedge PCLK); #1;
        cfg_vec   = v;
        cfg_start = 1'b1;
        @(posedge PCLK); #1;
        cfg_start = 1'b0;
        n = 0;
        while (!cfg_done && n < 100) begin
            @(posedge PCLK); #1;
            n++;
        end
        chk(nm, 64'(n), 64'd17);
    endtask

    task automatic wait_neg(input int which, input string nm);
        int n;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!((which == 0) ? out_ack : irq_valid) && n < 60);
        chk(nm, 64'((which == 0) ? out_ack : irq_valid), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    n;
        item_t it;

        // Reset state
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("reset_outputs", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, cfg_done, out_ack,
                              irq_valid, irq_vec, err}, 64'd0);
        chk("reset_dut4", {psel4, cfg_done4, err4}, 64'd0);
        PRESET = 1'b0;

        // IO_NUM=4 config: four writes, cfg_done 9 cycles after cfg_start.
        // Meanwhile out_req/INT_OR on the main instance must be ignored in IDLE.
        for (int i = 0; i < 4; i++) begin
            it.kind = K_APB; it.addr = 8'(4 * i); it.wr = 1'b1;
            it.data = 32'(8'h0C + i);
            q4.push_back(it);
        end
        @(posedge PCLK); #1;
        cfg_start4 = 1'b1;
        out_req    = 1'b1;
        INT_OR     = 1'b1;
        @(posedge PCLK); #1;
        cfg_start4 = 1'b0;
        n = 0;
        while (!cfg_done4 && n < 100) begin
            @(posedge PCLK); #1;
            n++;
        end
        chk("dut4_cfg_latency", 64'(n), 64'd9);
        chk("idle_ignores_req", {PSEL, cfg_done}, 64'd0);
        out_req = 1'b0;
        INT_OR  = 1'b0;

        // Main config: 8 writes, latency 2*8+1
        run_cfg(64'h1312_1110_0F0E_0D0C, "cfg_latency");
        chk("err_clean", 64'(err), 64'd0);

        // GPIO_OUT write with 3 wait states
        push(K_APB, 8'hA0, 1'b1, 32'hA5);
        push(K_ACK, 8'h00, 1'b0, 32'h0);
        @(posedge PCLK); #1;
        ws_target = 3;
        out_data  = 8'hA5;
        out_req   = 1'b1;
        wait_neg(0, "out_ack_seen");
        out_req = 1'b0;
        repeat (3) @(posedge PCLK); #1;
        ws_target = 0;
        chk("run_after_out", 64'(cfg_done), 64'd1);

        // INT_OR and out_req together: interrupt first, then the write
        intr_val = 32'h12;
        push(K_APB, 8'h80, 1'b0, 32'h0);
        push(K_APB, 8'h80, 1'b1, 32'h12);
        push(K_IRQ, 8'h00, 1'b0, 32'h12);
        push(K_APB, 8'hA0, 1'b1, 32'h3C);
        push(K_ACK, 8'h00, 1'b0, 32'h0);
        @(posedge PCLK); #1;
        INT_OR   = 1'b1;
        out_req  = 1'b1;
        out_data = 8'h3C;
        wait_neg(1, "irq_valid_seen");
        INT_OR = 1'b0;
        wait_neg(0, "out_ack_after_irq");
        out_req = 1'b0;
        repeat (3) @(posedge PCLK); #1;
        chk("irq_vec_held", 64'(irq_vec), 64'h12);

        // INTR reads zero: read only, no clear, no irq_valid
        intr_val = 32'h0;
        push(K_APB, 8'h80, 1'b0, 32'h0);
        @(posedge PCLK); #1;
        INT_OR = 1'b1;
        repeat (8) @(posedge PCLK); #1;
        INT_OR = 1'b0;
        repeat (3) @(posedge PCLK); #1;
        chk("irq_vec_zero", 64'(irq_vec), 64'h0);
        chk("run_after_zero", 64'(cfg_done), 64'd1);
        chk("sb_drained_run", 64'(sbq.size()), 64'd0);

        // PSLVERR on CONFIG_2: err set, sequence still completes
        @(negedge PCLK);
        PRESET = 1'b1;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        slverr_en   = 1'b1;
        slverr_addr = 8'h08;
        run_cfg(64'h8877_6655_4433_2211, "cfg_latency_slverr");
        chk("err_sticky", 64'(err), 64'd1);
        chk("cfg_done_slverr", 64'(cfg_done), 64'd1);
        slverr_en = 1'b0;

        // Reset during ACCESS of a CFG write
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET    = 1'b0;
        ws_target = 100;
        cfg_vec   = 64'h8877_6655_4433_2211;
        cfg_start = 1'b1;
        @(posedge PCLK); #1;
        cfg_start = 1'b0;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!(PSEL && PENABLE) && n < 20);
        chk("access_reached", {PSEL, PENABLE, PADDR}, {1'b1, 1'b1, 8'h00});
        PRESET    = 1'b1;
        ws_target = 0;
        @(negedge PCLK);
        chk("reset_psel", 64'(PSEL), 64'd0);
        chk("reset_mid_outputs", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, cfg_done, out_ack,
                                  irq_valid, irq_vec, err}, 64'd0);
        PRESET = 1'b0;
        run_cfg(64'h0102_0304_0506_0708, "cfg_latency_restart");

        repeat (3) @(posedge PCLK); #1;
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        chk("sb4_drained", 64'(q4.size()), 64'd0);
        chk("dut4_quiet", {out_ack4, irq_valid4, irq_vec4, err4}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
